// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth radix-4 partial-product datapath.
package booth_pkg;

  localparam int unsigned NDIG = 4;  // radix-4 digits per 8-bit multiplier
  localparam int unsigned PPW  = 9;  // partial-product width (room for 2M)

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_e;

  // Map a multiplier triplet {q[2j+1], q[2j], q[2j-1]} to its Booth digit.
  function automatic digit_e recode(input logic [2:0] trip);
    digit_e d;
    unique case (trip)
      3'b000, 3'b111: d = ZERO;
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen_if.sv
// Request/partial-product bundle between the multiplier front end and booth_pp_gen.
interface booth_pp_gen_if;
  import booth_pkg::*;

  logic            start;
  logic [7:0]      mcand;
  logic [7:0]      mplier;
  logic [PPW-1:0]  pp_data;
  logic            pp_neg;
  logic [NDIG-1:0] pp_load;
  logic            busy;
  logic            done;

  // Requester side: issues operands, observes partial products.
  modport master (
    output start, mcand, mplier,
    input  pp_data, pp_neg, pp_load, busy, done
  );

  // Generator side.
  modport slave (
    input  start, mcand, mplier,
    output pp_data, pp_neg, pp_load, busy, done
  );

endinterface

// File: rtl/booth_digit_enc.sv
// Combinational Booth radix-4 digit encoder: triplet + multiplicand -> magnitude and sign.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0]     triplet,
  input  logic [7:0]     m,
  output logic [PPW-1:0] sel,
  output logic           neg
);

  digit_e digit;

  // Select |digit|*M and flag negative digits; zero digits never set neg.
  always_comb begin
    digit = recode(triplet);
    sel   = '0;
    neg   = 1'b0;
    unique case (digit)
      ZERO: sel = '0;
      POS1: sel = {m[7], m};
      POS2: sel = {m, 1'b0};
      NEG1: begin
        sel = {m[7], m};
        neg = 1'b1;
      end
      NEG2: begin
        sel = {m, 1'b0};
        neg = 1'b1;
      end
      default: sel = '0;
    endcase
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Sequential Booth radix-4 partial-product generator: one digit per cycle, registered outputs.
module booth_pp_gen
  import booth_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  booth_pp_gen_if.slave  bus
);

  state_e          state_q;
  logic [1:0]      j_q;      // index of the digit currently on the outputs
  logic [7:0]      m_q;
  logic [7:0]      q_q;
  logic [PPW-1:0]  pp_data_q;
  logic            pp_neg_q;
  logic [NDIG-1:0] pp_load_q;
  logic            busy_q;
  logic            done_q;

  logic [7:0]      enc_m;
  logic [7:0]      enc_q;
  logic [1:0]      enc_j;
  logic [2:0]      enc_trip;
  logic [PPW-1:0]  enc_sel;
  logic            enc_neg;
  logic [PPW-1:0]  pp_word;

  // Encode the digit to be registered next. In IDLE the operands are still on the
  // bus, so digit 0 is formed straight from the inputs to appear the cycle after start.
  always_comb begin
    enc_m    = (state_q == IDLE) ? bus.mcand  : m_q;
    enc_q    = (state_q == IDLE) ? bus.mplier : q_q;
    enc_j    = (state_q == IDLE) ? 2'd0 : j_q + 2'd1;
    enc_trip = 3'({enc_q, 1'b0} >> {enc_j, 1'b0});
    pp_word  = enc_neg ? ~enc_sel : enc_sel;
  end

  booth_digit_enc u_enc (
    .triplet (enc_trip),
    .m       (enc_m),
    .sel     (enc_sel),
    .neg     (enc_neg)
  );

  // Control FSM, operand capture and output registers; outputs default to zero each cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      j_q       <= 2'd0;
      m_q       <= '0;
      q_q       <= '0;
      pp_data_q <= '0;
      pp_neg_q  <= 1'b0;
      pp_load_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pp_data_q <= '0;
      pp_neg_q  <= 1'b0;
      pp_load_q <= '0;
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= GEN;
            j_q       <= 2'd0;
            m_q       <= bus.mcand;
            q_q       <= bus.mplier;
            pp_data_q <= pp_word;
            pp_neg_q  <= enc_neg;
            pp_load_q <= 4'b0001;
            busy_q    <= 1'b1;
          end
        end
        GEN: begin
          if (j_q == 2'd3) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            j_q       <= enc_j;
            pp_data_q <= pp_word;
            pp_neg_q  <= enc_neg;
            pp_load_q <= 4'b0001 << enc_j;
          end
        end
        DONE: begin
          state_q <= IDLE;
          j_q     <= 2'd0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pp_data = pp_data_q;
  assign bus.pp_neg  = pp_neg_q;
  assign bus.pp_load = pp_load_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_booth_pp_gen.sv
// Self-checking bench for booth_pp_gen against an arithmetic Booth-digit model.
module tb_booth_pp_gen;

  logic clk = 1'b0;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  booth_pp_gen_if bus ();

  booth_pp_gen dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Digit value d = -2*q[2j+1] + q[2j] + q[2j-1]; partial product is d*M in 9 bits,
  // written as one's complement of |d|*M plus a hot one when d is negative.
  function automatic void exp_digit(input logic [7:0] m, input logic [7:0] q, input int j,
                                    output logic [8:0] data, output logic neg);
    logic [8:0] qx;
    int d;
    int p;
    qx   = {q, 1'b0};
    d    = -2 * int'(qx[2*j+2]) + int'(qx[2*j+1]) + int'(qx[2*j]);
    p    = (d < 0 ? -d : d) * int'($signed(m));
    data = 9'(p);
    neg  = (d < 0);
    if (neg) data = ~data;
  endfunction

  // One full operation starting at the next edge; checks every cycle and the product.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q, input string tag);
    int sum;
    int prod;
    logic [8:0] ed;
    logic en;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = m;
    bus.mplier = q;
    sum = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      bus.start  = 1'b0;
      bus.mcand  = 8'($urandom);
      bus.mplier = 8'($urandom);
      exp_digit(m, q, j, ed, en);
      n_tests++;
      if (bus.pp_load !== 4'(1 << j) || bus.pp_data !== ed || bus.pp_neg !== en ||
          bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s digit%0d M=%h Q=%h: load=%b data=%h neg=%b busy=%b done=%b, want load=%b data=%h neg=%b busy=1 done=0",
                 tag, j, m, q, bus.pp_load, bus.pp_data, bus.pp_neg, bus.busy, bus.done,
                 4'(1 << j), ed, en);
      end
      sum += (int'($signed(bus.pp_data)) + int'(bus.pp_neg)) * (1 << (2 * j));
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1 || bus.pp_load !== 4'b0 || bus.pp_data !== 9'h0 ||
        bus.pp_neg !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_cycle: done=%b load=%b data=%h neg=%b busy=%b, want 1 0000 000 0 1",
               tag, bus.done, bus.pp_load, bus.pp_data, bus.pp_neg, bus.busy);
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: done=%b busy=%b, want 0 0", tag, bus.done, bus.busy);
    end
    prod = int'($signed(m)) * int'($signed(q));
    n_tests++;
    if (sum !== prod) begin
      n_fail++;
      $display("FAIL %s product M=%h Q=%h: got %0d want %0d", tag, m, q, sum, prod);
    end
  endtask

  task automatic test_reset();
    clr        = 1'b1;
    bus.start  = 1'b0;
    bus.mcand  = 8'h0;
    bus.mplier = 8'h0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.pp_data !== 9'h0 || bus.pp_neg !== 1'b0 || bus.pp_load !== 4'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: data=%h neg=%b load=%b busy=%b done=%b, want all zero",
               bus.pp_data, bus.pp_neg, bus.pp_load, bus.busy, bus.done);
    end
    // Start asserted with clr must be dropped.
    bus.start = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.pp_load !== 4'b0) begin
      n_fail++;
      $display("FAIL clr_vs_start: busy=%b load=%b, want 0 0000", bus.busy, bus.pp_load);
    end
  endtask

  task automatic test_directed();
    run_op(8'd3,  8'd5,  "m3_q5");
    run_op(8'h80, 8'h80, "m80_q80");
    run_op(8'd7,  8'hFF, "m7_qff");
    run_op(8'h80, 8'h7F, "m80_q7f");
    run_op(8'h7F, 8'h80, "m7f_q80");
    run_op(8'h00, 8'hAA, "m0_qaa");
  endtask

  task automatic test_ignored_start();
    int loads;
    int dones;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 8'($urandom);
    bus.mplier = 8'($urandom);
    loads = 0;
    dones = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      loads += $countones(bus.pp_load);
      dones += int'(bus.done);
      bus.start = (c == 2 || c == 5);
    end
    bus.start = 1'b0;
    n_tests++;
    if (loads != 4 || dones != 1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start: loads=%0d dones=%0d busy=%b, want 4 1 0", loads, dones, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    first  = -1;
    second = -1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 8'($urandom);
    bus.mplier = 8'($urandom);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.pp_load === 4'b0001) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    bus.start = 1'b0;
    n_tests++;
    if (first != 1 || second != 7) begin
      n_fail++;
      $display("FAIL back_to_back: first load at +%0d second at +%0d, want +1 +7", first, second);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_clr_abort();
    int stray;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 8'h55;
    bus.mplier = 8'h6B;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_tests++;
    if (bus.pp_data !== 9'h0 || bus.pp_neg !== 1'b0 || bus.pp_load !== 4'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_abort: data=%h neg=%b load=%b busy=%b done=%b, want all zero",
               bus.pp_data, bus.pp_neg, bus.pp_load, bus.busy, bus.done);
    end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      stray += int'(bus.done) + $countones(bus.pp_load) + int'(bus.busy);
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL clr_no_resume: %0d stray active samples, want 0", stray);
    end
    run_op(8'hC3, 8'h9D, "after_clr");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      run_op(8'($urandom), 8'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_back_to_back();
    test_clr_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
